// File: rtl/same_o_reader_pkg.sv
// -----------------------------------------------------------------------------
// same_o_reader_pkg
//   Shared definitions for the "same"-size output path: FSM state encoding
//   and default widths. The convolution core and the output controller use
//   the same widths, so changing them here keeps the three blocks in step.
// -----------------------------------------------------------------------------
package same_o_reader_pkg;

    // Default widths
    localparam int SOR_IW  = 5;   // index / output-memory address width
    localparam int SOR_CAW = 6;   // convolution-result memory address width
    localparam int SOR_DW  = 16;  // sample data width

    // FSM state encoding (2 bits)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_CAPT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        READ = ST_READ,
        CAPT = ST_CAPT,
        DONE = ST_DONE
    } sor_state_e;

endpackage : same_o_reader_pkg

// File: rtl/same_idx_cnt.sv
// -----------------------------------------------------------------------------
// same_idx_cnt
//   Sample index register for the same_o_reader sequencer.
//
// Ports
//   clk   in   1   system clock, posedge
//   rstn  in   1   asynchronous active-low reset
//   clr   in   1   synchronous clear to 0 (has priority over inc)
//   inc   in   1   increment by one
//   size  in   IW  latched transfer size
//   idx   out  IW  current index i
//   last  out  1   combinational terminal flag, high when i == size-1
// -----------------------------------------------------------------------------
module same_idx_cnt
    import same_o_reader_pkg::*;
#(
    parameter int IW = SOR_IW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          inc,
    input  logic [IW-1:0] size,
    output logic [IW-1:0] idx,
    output logic          last
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + IW'(1);
        end
    end

    // Only consulted while a non-empty transfer is running, so size-1
    // never underflows in a way that matters.
    assign last = (idx == (size - IW'(1)));

endmodule : same_idx_cnt

// File: rtl/same_o_reader.sv
// -----------------------------------------------------------------------------
// same_o_reader
//   Output-side sequencer for the "same"-size convolution result. Copies the
//   central sz_same samples of the full convolution memory, conv[offset+i],
//   into the output memory at out[i] for i = 0 .. sz_same-1. Each sample
//   takes two cycles: a READ cycle that strobes the conv memory and a CAPT
//   cycle that writes the returned data to the output memory.
//
// Ports
//   clk        in   1    system clock, posedge
//   rstn       in   1    asynchronous active-low reset
//   start_i    in   1    start pulse, sampled only in IDLE
//   sz_same_i  in   IW   number of samples to transfer, latched at start
//   offset_i   in   CAW  first conv-memory address, latched at start
//   rd_en_o    out  1    conv-memory read strobe (registered)
//   rd_addr_o  out  CAW  conv-memory read address, offset+i mod 2^CAW
//   rd_data_i  in   DW   conv-memory read data, valid 1 cycle after rd_en_o
//   wr_en_o    out  1    output-memory write strobe (registered)
//   wr_addr_o  out  IW   output-memory write address, i
//   wr_data_o  out  DW   output-memory write data
//   busy_o     out  1    high whenever the FSM is not in IDLE
//   done_o     out  1    one-cycle completion pulse
// -----------------------------------------------------------------------------
module same_o_reader
    import same_o_reader_pkg::*;
#(
    parameter int IW  = SOR_IW,
    parameter int CAW = SOR_CAW,
    parameter int DW  = SOR_DW
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           start_i,
    input  logic [IW-1:0]  sz_same_i,
    input  logic [CAW-1:0] offset_i,
    output logic           rd_en_o,
    output logic [CAW-1:0] rd_addr_o,
    input  logic [DW-1:0]  rd_data_i,
    output logic           wr_en_o,
    output logic [IW-1:0]  wr_addr_o,
    output logic [DW-1:0]  wr_data_o,
    output logic           busy_o,
    output logic           done_o
);

    sor_state_e     state;
    logic [IW-1:0]  size_q;
    logic [CAW-1:0] offset_q;

    logic [IW-1:0]  idx;
    logic           last;
    logic           accept;
    logic           cnt_inc;
    logic [CAW-1:0] addr_next;

    // A start is only honoured from IDLE; in every other state it is dropped.
    assign accept  = (state == IDLE) && start_i;
    assign cnt_inc = (state == CAPT) && !last;

    // Address of the read that follows the current CAPT: offset + (i+1).
    // CAW-bit arithmetic, so the sum wraps silently past the top of memory.
    assign addr_next = offset_q + CAW'(idx) + CAW'(1);

    same_idx_cnt #(
        .IW (IW)
    ) u_idx_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (accept),
        .inc  (cnt_inc),
        .size (size_q),
        .idx  (idx),
        .last (last)
    );

    // State and all control outputs are registered together: each output
    // value is decided on the edge that enters the state it belongs to.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            size_q    <= '0;
            offset_q  <= '0;
            rd_en_o   <= 1'b0;
            rd_addr_o <= '0;
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            rd_en_o   <= 1'b0;
            rd_addr_o <= '0;
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            done_o    <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_i) begin
                        busy_o <= 1'b1;
                        if (sz_same_i != '0) begin
                            size_q    <= sz_same_i;
                            offset_q  <= offset_i;
                            rd_en_o   <= 1'b1;
                            rd_addr_o <= offset_i;  // i = 0
                            state     <= READ;
                        end else begin
                            // Empty transfer: straight to the completion pulse.
                            done_o <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end

                READ: begin
                    // Memory returns data during CAPT; the write uses it then.
                    wr_en_o   <= 1'b1;
                    wr_addr_o <= idx;
                    state     <= CAPT;
                end

                CAPT: begin
                    if (last) begin
                        done_o <= 1'b1;
                        state  <= DONE;
                    end else begin
                        rd_en_o   <= 1'b1;
                        rd_addr_o <= addr_next;
                        state     <= READ;
                    end
                end

                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Read data only arrives during CAPT, so the write data is passed
    // straight through, gated so it reads as 0 outside a write.
    assign wr_data_o = wr_en_o ? rd_data_i : '0;

endmodule : same_o_reader
